// File: rtl/id_ex_if.sv
// id_ex_if: ID/EX stage bundle. It carries the ID-side operands and controls, the WB write port,
// flush and mem_stall, and returns the registered EX fields, stall_if_id and the perf counters.
// slave = the stage itself, master = the driver of the ID/WB/hazard side.
interface id_ex_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 32
);
    logic              id_valid;
    logic [DATA_W-1:0] id_pc;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rd;
    logic [DATA_W-1:0] id_rs1_data;
    logic [DATA_W-1:0] id_rs2_data;
    logic [DATA_W-1:0] id_imm;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic [CTRL_W-1:0] id_ctrl;
    logic              wb_reg_write;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              flush;
    logic              mem_stall;
    logic              stall_if_id;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_pc;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic [DATA_W-1:0] ex_rs1_data;
    logic [DATA_W-1:0] ex_rs2_data;
    logic [DATA_W-1:0] ex_imm;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CNT_W-1:0]  lu_stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_rs1_data, id_rs2_data, id_imm, id_reg_write, id_mem_read, id_mem_write, id_ctrl,
               wb_reg_write, wb_rd, wb_data, flush, mem_stall,
        output stall_if_id, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data,
               ex_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_ctrl, lu_stall_cnt, flush_cnt
    );
    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_rs1_data, id_rs2_data, id_imm, id_reg_write, id_mem_read, id_mem_write, id_ctrl,
               wb_reg_write, wb_rd, wb_data, flush, mem_stall,
        input  stall_if_id, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data,
               ex_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_ctrl, lu_stall_cnt, flush_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection, flush bubbles,
// memory-stall freeze and same-cycle WB bypass into the latched operand data.
// Ports: clk (rising edge), rst_n (async active-low), bus (id_ex_if.slave: ID fields, WB port,
// flush, mem_stall in; stall_if_id, ex_* fields, lu_stall_cnt, flush_cnt out).
// Optional macro PERF_CNT_EN: enables the saturating load-use/flush counters; otherwise they read 0.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 32
) (
    input logic   clk,
    input logic   rst_n,
    id_ex_if.slave bus
);
    logic              load_use;
    logic              bubble;
    logic [DATA_W-1:0] rs1_fwd;
    logic [DATA_W-1:0] rs2_fwd;
    assign load_use = bus.ex_valid & bus.ex_mem_read & (bus.ex_rd != {REG_AW{1'b0}}) & bus.id_valid &
                      ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                       (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd)));
    // A flush already kills the consumer, so it need not hold IF/ID.
    assign bus.stall_if_id = bus.mem_stall | (load_use & ~bus.flush);
    assign bubble = bus.flush | load_use;
    assign rs1_fwd = (bus.wb_reg_write & (bus.wb_rd != {REG_AW{1'b0}}) & (bus.wb_rd == bus.id_rs1))
                     ? bus.wb_data : bus.id_rs1_data;
    assign rs2_fwd = (bus.wb_reg_write & (bus.wb_rd != {REG_AW{1'b0}}) & (bus.wb_rd == bus.id_rs2))
                     ? bus.wb_data : bus.id_rs2_data;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ex_valid     <= 1'b0;
            bus.ex_pc        <= '0;
            bus.ex_rs1       <= '0;
            bus.ex_rs2       <= '0;
            bus.ex_rd        <= '0;
            bus.ex_rs1_data  <= '0;
            bus.ex_rs2_data  <= '0;
            bus.ex_imm       <= '0;
            bus.ex_reg_write <= 1'b0;
            bus.ex_mem_read  <= 1'b0;
            bus.ex_mem_write <= 1'b0;
            bus.ex_ctrl      <= {CTRL_W{1'b0}};
        end else if (!bus.mem_stall) begin
            if (bubble) begin
                // Data fields hold; only the fields that give the slot meaning are cleared.
                bus.ex_valid     <= 1'b0;
                bus.ex_rd        <= '0;
                bus.ex_reg_write <= 1'b0;
                bus.ex_mem_read  <= 1'b0;
                bus.ex_mem_write <= 1'b0;
                bus.ex_ctrl      <= {CTRL_W{1'b0}};
            end else begin
                bus.ex_valid     <= bus.id_valid;
                bus.ex_pc        <= bus.id_pc;
                bus.ex_rs1       <= bus.id_rs1;
                bus.ex_rs2       <= bus.id_rs2;
                bus.ex_rs1_data  <= rs1_fwd;
                bus.ex_rs2_data  <= rs2_fwd;
                bus.ex_imm       <= bus.id_imm;
                bus.ex_rd        <= bus.id_valid ? bus.id_rd : '0;
                bus.ex_reg_write <= bus.id_valid & bus.id_reg_write;
                bus.ex_mem_read  <= bus.id_valid & bus.id_mem_read;
                bus.ex_mem_write <= bus.id_valid & bus.id_mem_write;
                bus.ex_ctrl      <= bus.id_valid ? bus.id_ctrl : {CTRL_W{1'b0}};
            end
        end
    end
`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] lu_cnt;
    logic [CNT_W-1:0] fl_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_cnt <= '0;
            fl_cnt <= '0;
        end else if (!bus.mem_stall) begin
            if (load_use & ~bus.flush & ~&lu_cnt) lu_cnt <= lu_cnt + 1'b1;
            if (bus.flush & bus.id_valid & ~&fl_cnt) fl_cnt <= fl_cnt + 1'b1;
        end
    end
    assign bus.lu_stall_cnt = lu_cnt;
    assign bus.flush_cnt    = fl_cnt;
`else
    assign bus.lu_stall_cnt = {CNT_W{1'b0}};
    assign bus.flush_cnt    = {CNT_W{1'b0}};
`endif
endmodule
